dff_bank_arbiter: RTL and testbench

- Round-robin write arbiter for a small register bank built from D flip-flops.
- NREQ requesters compete to write one WIDTH-bit word per cycle into a DEPTH-entry bank; one shared read port returns any entry.
- Sits between independent producer blocks and the shared flip-flop storage. It sequences every bank update and guarantees one writer per cycle.

---
 rtl/dff_bank_arbiter_if.sv | 27 ++
 rtl/dff_bank_arbiter.sv | 95 +++++++++
 tb/tb_dff_bank_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the round-robin register-bank arbiter: write requests,
// grant/write status and the shared read port.
interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic                  wr_valid;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output req, req_addr, req_data, clr, rd_addr,
        input  gnt, wr_valid, wr_addr, rd_data
    );

    modport slave (
        input  req, req_addr, req_data, clr, rd_addr,
        output gnt, wr_valid, wr_addr, rd_data
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a DEPTH x WIDTH flip-flop bank with one
// combinational read port; at most one write per cycle.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic               clk,
    input logic               rst,
    dff_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [WIDTH-1:0] bank [DEPTH];
    logic [PW-1:0]    ptr_p1;
    logic [NREQ-1:0]  gnt_p1;
    logic             wr_valid_p1;
    logic [AW-1:0]    wr_addr_p1;

    logic [NREQ-1:0]  elig_p0;
    logic             found_p0;
    logic [PW-1:0]    win_p0;
    logic [PW-1:0]    ptr_nxt_p0;
    logic [NREQ-1:0]  onehot_p0;
    logic [AW-1:0]    win_addr_p0;
    logic [WIDTH-1:0] win_data_p0;
    logic [WIDTH-1:0] rd_data_c;

    // Stage p0: a requester granted last cycle sits out one cycle
    assign elig_p0 = bus.req & ~gnt_p1;

    always_comb begin
        int idx;
        idx      = 0;
        found_p0 = 1'b0;
        win_p0   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_p1) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found_p0 && elig_p0[PW'(idx)]) begin
                found_p0 = 1'b1;
                win_p0   = PW'(idx);
            end
        end
    end

    always_comb begin
        onehot_p0         = '0;
        onehot_p0[win_p0] = 1'b1;
    end

    assign ptr_nxt_p0  = (int'(win_p0) == NREQ - 1) ? '0 : win_p0 + 1'b1;
    assign win_addr_p0 = bus.req_addr[int'(win_p0)*AW +: AW];
    assign win_data_p0 = bus.req_data[int'(win_p0)*WIDTH +: WIDTH];

    // Stage p1: bank update and registered write status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            ptr_p1      <= '0;
            gnt_p1      <= '0;
            wr_valid_p1 <= 1'b0;
            wr_addr_p1  <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            gnt_p1      <= '0;
            wr_valid_p1 <= 1'b0;
        end else if (found_p0) begin
            // Out-of-range addresses fall through the loop and leave the bank alone
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(win_addr_p0) == i) bank[i] <= win_data_p0;
            end
            gnt_p1      <= onehot_p0;
            wr_valid_p1 <= 1'b1;
            wr_addr_p1  <= win_addr_p0;
            ptr_p1      <= ptr_nxt_p0;
        end else begin
            gnt_p1      <= '0;
            wr_valid_p1 <= 1'b0;
        end
    end

    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(bus.rd_addr) == i) rd_data_c = bank[i];
        end
    end

    assign bus.gnt      = gnt_p1;
    assign bus.wr_valid = wr_valid_p1;
    assign bus.wr_addr  = wr_addr_p1;
    assign bus.rd_data  = rd_data_c;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: a DEPTH=4 instance for arbitration/clear,
// and a DEPTH=3 instance for out-of-range writes and asynchronous reset.
module tb_dff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();
    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus3 ();

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(4), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(3), .AW(AW)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input string tag);
        bus.rd_addr = a;
        #1;
        check(tag, 32'(bus.rd_data), 32'(e));
    endtask

    task automatic rd3(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input string tag);
        bus3.rd_addr = a;
        #1;
        check(tag, 32'(bus3.rd_data), 32'(e));
    endtask

    task automatic chk_wr(input string tag, input logic [NREQ-1:0] g, input logic v, input logic [AW-1:0] a);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, "_vld"}, 32'(bus.wr_valid), 32'(v));
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'(a));
    endtask

    initial begin
        bus.clr       = 1'b0;
        bus.rd_addr   = '0;
        bus.req       = 4'b1111;
        bus.req_addr  = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus3.clr      = 1'b0;
        bus3.rd_addr  = '0;
        bus3.req      = '0;
        bus3.req_addr = '0;
        bus3.req_data = '0;

        // Reset held with all requests active
        tick;
        tick;
        chk_wr("reset", 4'b0000, 1'b0, 2'd0);
        rd(2'd0, 8'h00, "reset_rd0");
        rd(2'd1, 8'h00, "reset_rd1");
        rd(2'd2, 8'h00, "reset_rd2");
        rd(2'd3, 8'h00, "reset_rd3");
        rst = 1'b1;

        // Round robin with all four requesting continuously
        tick; chk_wr("rr0", 4'b0001, 1'b1, 2'd0);
        tick; chk_wr("rr1", 4'b0010, 1'b1, 2'd1);
        tick; chk_wr("rr2", 4'b0100, 1'b1, 2'd2);
        tick; chk_wr("rr3", 4'b1000, 1'b1, 2'd3);
        tick; chk_wr("rr4", 4'b0001, 1'b1, 2'd0);
        rd(2'd0, 8'h11, "rr_rd0");
        rd(2'd1, 8'h22, "rr_rd1");
        rd(2'd2, 8'h33, "rr_rd2");
        rd(2'd3, 8'h44, "rr_rd3");

        // Pointer wrap: 3 wins from pointer 1, then 0, then 3 again
        bus.req = 4'b1000;
        tick; chk_wr("wrap_a", 4'b1000, 1'b1, 2'd3);
        bus.req = 4'b1001;
        tick; chk_wr("wrap_b", 4'b0001, 1'b1, 2'd0);
        tick; chk_wr("wrap_c", 4'b1000, 1'b1, 2'd3);
        bus.req = 4'b0000;
        tick; chk_wr("idle", 4'b0000, 1'b0, 2'd3);

        // Single writer; old value visible until the write edge
        bus.req_addr[5:4]   = 2'd3;
        bus.req_data[23:16] = 8'hA5;
        rd(2'd3, 8'h44, "no_bypass");
        bus.req = 4'b0100;
        tick; chk_wr("single", 4'b0100, 1'b1, 2'd3);
        rd(2'd3, 8'hA5, "single_rd");

        // Restore entry 3, then clear with requester 1 pending
        bus.req = 4'b1000;
        tick; chk_wr("restore", 4'b1000, 1'b1, 2'd3);
        rd(2'd3, 8'h44, "restore_rd");
        bus.req_data[15:8] = 8'h5A;
        bus.clr = 1'b1;
        bus.req = 4'b0010;
        tick;
        check("clr_gnt", 32'(bus.gnt), 32'h0);
        check("clr_vld", 32'(bus.wr_valid), 32'h0);
        rd(2'd0, 8'h00, "clr_rd0");
        rd(2'd1, 8'h00, "clr_rd1");
        rd(2'd2, 8'h00, "clr_rd2");
        rd(2'd3, 8'h00, "clr_rd3");
        bus.clr = 1'b0;
        tick; chk_wr("post_clr", 4'b0010, 1'b1, 2'd1);
        rd(2'd1, 8'h5A, "post_clr_rd1");
        rd(2'd0, 8'h00, "post_clr_rd0");

        // DEPTH=3 instance: in-range write, then out-of-range address 3
        bus.req       = 4'b0000;
        bus3.req_addr = {2'd0, 2'd0, 2'd3, 2'd2};
        bus3.req_data = {8'h00, 8'h00, 8'hEE, 8'h77};
        bus3.req      = 4'b0001;
        tick;
        check("d4_idle_gnt", 32'(bus.gnt), 32'h0);
        check("d3_gnt0", 32'(bus3.gnt), 32'h1);
        rd3(2'd2, 8'h77, "d3_rd2");
        bus3.req = 4'b0010;
        tick;
        check("oor_gnt", 32'(bus3.gnt), 32'h2);
        check("oor_vld", 32'(bus3.wr_valid), 32'h1);
        check("oor_addr", 32'(bus3.wr_addr), 32'h3);
        rd3(2'd0, 8'h00, "oor_rd0");
        rd3(2'd1, 8'h00, "oor_rd1");
        rd3(2'd2, 8'h77, "oor_rd2");
        rd3(2'd3, 8'h00, "oor_rd3");

        // Asynchronous reset while the grant pulse is high, between clock edges
        rst = 1'b0;
        #1;
        check("arst_gnt", 32'(bus3.gnt), 32'h0);
        check("arst_vld", 32'(bus3.wr_valid), 32'h0);
        check("arst_addr", 32'(bus3.wr_addr), 32'h0);
        rd3(2'd2, 8'h00, "arst_rd2");
        rd(2'd1, 8'h00, "arst_d4_rd1");
        bus3.req = 4'b0000;
        tick;
        check("arst_hold_gnt", 32'(bus3.gnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
